// File: rtl/simon_pattern_sequencer_if.sv
// Bus between the Simon game mode FSM, pattern memory, LED driver and the step sequencer.
// start_* and in_valid are single-cycle strobes with no ready: each is taken only when the sequencer is in a state that accepts it (IDLE, R_WAIT) and dropped otherwise.
interface simon_pattern_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int PAT_W  = 4
);
  logic              start_play;
  logic              start_repeat;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] mem_raddr;
  logic [PAT_W-1:0]  mem_rdata;
  logic              in_valid;
  logic [PAT_W-1:0]  in_pattern;
  logic [PAT_W-1:0]  leds;
  logic              busy;
  logic              play_done;
  logic              pass;
  logic              fail;
  logic [2:0]        state_dbg;

  modport slave (
    input  start_play, start_repeat, count, mem_rdata, in_valid, in_pattern,
    output mem_raddr, leds, busy, play_done, pass, fail, state_dbg
  );

  modport master (
    output start_play, start_repeat, count, mem_rdata, in_valid, in_pattern,
    input  mem_raddr, leds, busy, play_done, pass, fail, state_dbg
  );
endinterface

// File: rtl/simon_pattern_sequencer.sv
// Simon pattern sequencer: timed playback of the stored pattern, or entry-by-entry checking of player input.
// Optional repeat-phase input timeout is enabled by defining SIMON_SEQ_TIMEOUT_EN.
module simon_pattern_sequencer #(
  parameter int ADDR_W         = 6,
  parameter int PAT_W          = 4,
  parameter int ON_CYCLES      = 3,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic rst,
  simon_pattern_sequencer_if.slave bus
);
  localparam int TMAX_OG = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TMAX    = (TIMEOUT_CYCLES > TMAX_OG) ? TIMEOUT_CYCLES : TMAX_OG;
  localparam int TW      = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_P_LOAD, S_P_ON, S_P_GAP, S_R_LOAD, S_R_WAIT, S_PASS, S_FAIL
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              play_done_q, play_done_d;
  logic              last_idx;

  assign last_idx = (idx_q == cnt_q - ADDR_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      raddr_q     <= '0;
      timer_q     <= '0;
      play_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      raddr_q     <= raddr_d;
      timer_q     <= timer_d;
      play_done_q <= play_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    play_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_play && bus.count != '0) begin
          cnt_d   = bus.count;
          idx_d   = '0;
          state_d = S_P_LOAD;
        end else if (bus.start_repeat && bus.count != '0) begin
          cnt_d   = bus.count;
          idx_d   = '0;
          state_d = S_R_LOAD;
        end
      end
      S_P_LOAD: begin
        timer_d = TW'(ON_CYCLES - 1);
        state_d = S_P_ON;
      end
      S_P_ON: begin
        if (timer_q == '0) begin
          timer_d = TW'(GAP_CYCLES - 1);
          state_d = S_P_GAP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_P_GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (last_idx) begin
          play_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_P_LOAD;
        end
      end
      S_R_LOAD: begin
        // Memory data for idx is not valid until R_WAIT, so entries here are dropped.
        timer_d = '0;
        state_d = S_R_WAIT;
      end
      S_R_WAIT: begin
        if (bus.in_valid) begin
          if (bus.in_pattern != bus.mem_rdata) begin
            state_d = S_FAIL;
          end else if (last_idx) begin
            state_d = S_PASS;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_R_LOAD;
          end
        end
`ifdef SIMON_SEQ_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_FAIL;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      S_PASS:  state_d = S_IDLE;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase
    // The read address always tracks the index the next state will work on.
    raddr_d = idx_d;
  end

  always_comb begin
    bus.leds = '0;
    case (state_q)
      S_P_ON:   bus.leds = bus.mem_rdata;
      S_R_WAIT: bus.leds = bus.in_valid ? bus.in_pattern : '0;
      S_PASS:   bus.leds = '1;
      S_FAIL:   bus.leds = bus.mem_rdata;
      default:  bus.leds = '0;
    endcase
  end

  assign bus.mem_raddr = raddr_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.play_done = play_done_q;
  assign bus.pass      = (state_q == S_PASS);
  assign bus.fail      = (state_q == S_FAIL);
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_simon_pattern_sequencer.sv
// Bench for simon_pattern_sequencer: directed scenarios with literal expectations plus
// randomized play/repeat operations checked every cycle against a behavioural model.
module tb_simon_pattern_sequencer;
  localparam int ADDR_W = 6;
  localparam int PAT_W  = 4;
  localparam int ON     = 3;
  localparam int GAP    = 2;
  localparam int TMO    = 1000;
  localparam int STEP   = 1 + ON + GAP;
  localparam int M_IDLE = 0, M_PLAY = 1, M_REP = 2, M_PASS = 3, M_FAIL = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simon_pattern_sequencer_if #(.ADDR_W(ADDR_W), .PAT_W(PAT_W)) bus ();

  simon_pattern_sequencer #(
    .ADDR_W(ADDR_W), .PAT_W(PAT_W), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [PAT_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_raddr];

  int n_pass  = 0;
  int n_total = 0;
  logic [PAT_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // behavioural model: playback position is pure arithmetic on cycles since start
  int m_mode = M_IDLE, m_t = 0, m_cnt = 0, m_idx = 0, m_addr = 0, m_tmo = 0;
  bit m_ready = 1'b0, m_done = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= M_IDLE; m_t <= 0; m_cnt <= 0; m_idx <= 0; m_addr <= 0;
      m_tmo <= 0; m_ready <= 1'b0; m_done <= 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_done <= 1'b0;
          if (bus.count != 0 && (bus.start_play || bus.start_repeat)) begin
            m_mode  <= bus.start_play ? M_PLAY : M_REP;
            m_cnt   <= int'(bus.count);
            m_t     <= 0;
            m_idx   <= 0;
            m_addr  <= 0;
            m_ready <= 1'b0;
          end
        end
        M_PLAY: begin
          if (m_t + 1 == m_cnt * STEP) begin
            m_mode <= M_IDLE;
            m_done <= 1'b1;
          end else begin
            m_t    <= m_t + 1;
            m_addr <= (m_t + 1) / STEP;
          end
        end
        M_REP: begin
          if (!m_ready) begin
            m_ready <= 1'b1;
            m_tmo   <= 0;
          end else if (bus.in_valid) begin
            if (bus.in_pattern != mem[m_idx]) m_mode <= M_FAIL;
            else if (m_idx == m_cnt - 1) m_mode <= M_PASS;
            else begin
              m_idx   <= m_idx + 1;
              m_addr  <= m_idx + 1;
              m_ready <= 1'b0;
            end
          end
`ifdef SIMON_SEQ_TIMEOUT_EN
          else if (m_tmo + 1 == TMO) m_mode <= M_FAIL;
          else m_tmo <= m_tmo + 1;
`endif
        end
        M_PASS:  m_mode <= M_IDLE;
        default: m_mode <= m_mode;
      endcase
    end
  end

  function automatic logic [PAT_W-1:0] model_leds();
    case (m_mode)
      M_PLAY: begin
        if ((m_t % STEP) >= 1 && (m_t % STEP) <= ON) return mem[m_t / STEP];
        return '0;
      end
      M_REP:   return (m_ready && bus.in_valid) ? bus.in_pattern : '0;
      M_PASS:  return '1;
      M_FAIL:  return mem[m_idx];
      default: return '0;
    endcase
  endfunction

  // every-cycle compare against the model
  always @(negedge clk) begin
    check("leds", 32'(bus.leds), 32'(model_leds()));
    check("busy", 32'(bus.busy), 32'(m_mode != M_IDLE));
    check("play_done", 32'(bus.play_done), 32'(m_done));
    check("pass", 32'(bus.pass), 32'(m_mode == M_PASS));
    check("fail", 32'(bus.fail), 32'(m_mode == M_FAIL));
    check("mem_raddr", 32'(bus.mem_raddr), 32'(m_addr));
  end

  // driver tasks
  task automatic do_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start_play   = 1'b0;
    bus.start_repeat = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_pattern   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) do_step();
    rst = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && m_mode != M_IDLE; i++) do_step();
    check(name, 32'(m_mode == M_IDLE), 32'd1);
  endtask

  task automatic load_demo_mem();
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
  endtask

  logic [PAT_W-1:0] lit_play [18] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0,
                                      4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0,
                                      4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};

  initial begin
    int busy_n;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = PAT_W'($urandom);
    clear_inputs();
    bus.count = '0;
    #1 rst = 1'b0;
    repeat (3) do_step();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_leds", 32'(bus.leds), 32'd0);
    check("reset_raddr", 32'(bus.mem_raddr), 32'd0);
    rst = 1'b1;
    do_step();

    // directed playback against a hand-written LED trace
    load_demo_mem();
    bus.count = 6'd3; bus.start_play = 1'b1;
    do_step();
    bus.start_play = 1'b0;
    foreach (lit_play[i]) exp_q.push_back(lit_play[i]);
    busy_n = 0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k <= 18) begin
        check("play_trace", 32'(bus.leds), 32'(exp_q.pop_front()));
        busy_n += int'(bus.busy);
      end else begin
        check("play_done_c19", 32'(bus.play_done), 32'd1);
        check("play_busy_c19", 32'(bus.busy), 32'd0);
      end
    end
    check("play_busy_cycles", 32'(busy_n), 32'd18);
    do_step();

    // reset during P_ON, then restart
    bus.start_play = 1'b1;
    do_step();
    bus.start_play = 1'b0;
    repeat (2) do_step();
    rst = 1'b0;
    #2;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_leds", 32'(bus.leds), 32'd0);
    do_step();
    rst = 1'b1;
    bus.start_play = 1'b1;
    do_step();
    bus.start_play = 1'b0;
    do_step();
    @(negedge clk);
    check("restart_leds", 32'(bus.leds), 32'h1);
    wait_idle("restart_idle", 100);
    do_step();

    // repeat pass, with an entry offered during R_LOAD that must be dropped
    bus.start_repeat = 1'b1;
    do_step();
    bus.start_repeat = 1'b0; bus.in_valid = 1'b1; bus.in_pattern = 4'h5;
    do_step();
    bus.in_pattern = 4'h1;
    @(negedge clk);
    check("rload_drop_idx", 32'(bus.mem_raddr), 32'd0);
    check("rwait_echo", 32'(bus.leds), 32'h1);
    do_step();
    bus.in_valid = 1'b0; do_step();
    bus.in_valid = 1'b1; bus.in_pattern = 4'h4; do_step();
    bus.in_valid = 1'b0; do_step();
    bus.in_valid = 1'b1; bus.in_pattern = 4'h8; do_step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pass_pulse", 32'(bus.pass), 32'd1);
    check("pass_leds", 32'(bus.leds), 32'hF);
    check("pass_nofail", 32'(bus.fail), 32'd0);
    do_step();
    @(negedge clk);
    check("pass_once", 32'(bus.pass), 32'd0);
    check("pass_idle", 32'(bus.busy), 32'd0);
    do_step();

    // repeat fail: second entry wrong, sticky through starts
    bus.start_repeat = 1'b1; do_step();
    bus.start_repeat = 1'b0; do_step();
    bus.in_valid = 1'b1; bus.in_pattern = 4'h1; do_step();
    bus.in_valid = 1'b0; do_step();
    bus.in_valid = 1'b1; bus.in_pattern = 4'h2; do_step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("fail_set", 32'(bus.fail), 32'd1);
    check("fail_leds", 32'(bus.leds), 32'h4);
    check("fail_raddr", 32'(bus.mem_raddr), 32'd1);
    for (int i = 0; i < 100; i++) begin
      do_step();
      bus.start_play   = ($urandom_range(0, 7) == 0);
      bus.start_repeat = ($urandom_range(0, 7) == 0);
    end
    clear_inputs();
    @(negedge clk);
    check("fail_hold", 32'(bus.fail), 32'd1);
    check("fail_hold_leds", 32'(bus.leds), 32'h4);
    check("fail_hold_raddr", 32'(bus.mem_raddr), 32'd1);
    do_reset();

    // both starts together select playback
    bus.start_play = 1'b1; bus.start_repeat = 1'b1; do_step();
    clear_inputs(); do_step();
    @(negedge clk);
    check("both_start_play", 32'(bus.leds), 32'h1);
    wait_idle("both_idle", 100);
    do_step();

    // count = 0 is ignored
    bus.count = '0; bus.start_play = 1'b1; do_step();
    bus.start_play = 1'b0; bus.start_repeat = 1'b1; do_step();
    bus.start_repeat = 1'b0;
    @(negedge clk);
    check("count0_busy", 32'(bus.busy), 32'd0);
    do_step();

    // randomized operations
    for (int op = 0; op < 40; op++) begin
      int kind;
      int fail_hold;
      for (int i = 0; i < 16; i++) mem[i] = PAT_W'($urandom);
      kind = $urandom_range(0, 9);
      bus.count        = (kind == 9) ? '0 : ADDR_W'($urandom_range(1, 6));
      bus.start_play   = (kind < 4) || (kind == 8);
      bus.start_repeat = (kind >= 4);
      do_step();
      clear_inputs();
      fail_hold = 0;
      for (int c = 0; c < 2000 && m_mode != M_IDLE; c++) begin
        bus.count        = ADDR_W'($urandom);
        bus.start_play   = ($urandom_range(0, 15) == 0);
        bus.start_repeat = ($urandom_range(0, 15) == 0);
        bus.in_valid     = ($urandom_range(0, 2) == 0);
        bus.in_pattern   = ($urandom_range(0, 11) == 0) ? PAT_W'($urandom) : mem[m_idx];
        if (m_mode == M_FAIL) fail_hold++;
        if (fail_hold > 4 || $urandom_range(0, 299) == 0) do_reset();
        else do_step();
      end
      clear_inputs();
      check("rand_op_done", 32'(m_mode == M_IDLE), 32'd1);
      do_step();
    end

    // repeat with no input at all
    do_reset();
    bus.count = 6'd2; bus.start_repeat = 1'b1; do_step();
    clear_inputs();
    repeat (TMO + 5) do_step();
    @(negedge clk);
`ifdef SIMON_SEQ_TIMEOUT_EN
    check("timeout_fail", 32'(bus.fail), 32'd1);
`else
    check("no_timeout_busy", 32'(bus.busy), 32'd1);
    check("no_timeout_fail", 32'(bus.fail), 32'd0);
`endif
    do_step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end
endmodule
